// File: rtl/mem_port_if.sv
// Request/response bus between the core and mem_port_ctrl.
// Each channel transfers on a posedge where valid && ready are both high.
// The ready signals never depend on the same-cycle valid.
interface mem_port_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_port_ctrl.sv
// Single-outstanding memory port with programmable latency and byte/half/word lanes.
// Optional macro MEMPORT_MISALIGN_CHK_EN rejects misaligned half/word accesses.
module mem_port_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int LATENCY   = 1,
  parameter int INIT_ZERO = 1
) (
  input  logic       clk,
  input  logic       rst,
  mem_port_if.slave  bus,
  output logic [1:0] dbgState
);
  localparam int         DEPTH = 1 << (ADDR_W - 2);
  localparam logic [3:0] LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t            state, stateNext;
  logic [3:0]        cnt, cntNext;
  logic              commit;

  logic              weQ, unsQ;
  logic [1:0]        sizeQ;
  logic [ADDR_W-1:0] addrQ;
  logic [31:0]       wdataQ;

  logic              opWe, opUns;
  logic [1:0]        opSize;
  logic [ADDR_W-1:0] opAddr;
  logic [31:0]       opWdata;

  logic [1:0]        lane;
  logic [ADDR_W-3:0] idx;
  logic              err;
  logic [3:0]        be;
  logic [31:0]       wWord, curWord, ldData;
  logic [7:0]        byteV;
  logic [15:0]       halfV;

  logic [31:0]       rdataQ;
  logic              errQ;

  logic [31:0] mem [DEPTH] = '{default: (INIT_ZERO != 0) ? 32'h0 : 32'hxxxx_xxxx};

  // With zero latency the commit edge is the accept edge, so decode straight off the bus.
  assign opWe    = (state == IDLE) ? bus.req_we       : weQ;
  assign opUns   = (state == IDLE) ? bus.req_unsigned : unsQ;
  assign opSize  = (state == IDLE) ? bus.req_size     : sizeQ;
  assign opAddr  = (state == IDLE) ? bus.req_addr     : addrQ;
  assign opWdata = (state == IDLE) ? bus.req_wdata    : wdataQ;

  assign lane    = opAddr[1:0];
  assign idx     = opAddr[ADDR_W-1:2];
  assign curWord = mem[idx];

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          cntNext = LAT;
          if (LATENCY == 0) begin
            stateNext = RESP;
            commit    = 1'b1;
          end else begin
            stateNext = WAIT;
          end
        end
      end
      WAIT: begin
        cntNext = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          stateNext = RESP;
          commit    = 1'b1;
          cntNext   = 4'd0;
        end
      end
      RESP: begin
        if (bus.rsp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    err    = (opSize == 2'b11);
`ifdef MEMPORT_MISALIGN_CHK_EN
    if ((opSize == 2'b01 && lane[0]) || (opSize == 2'b10 && lane != 2'b00)) err = 1'b1;
`endif
    be     = 4'b0000;
    wWord  = opWdata;
    ldData = 32'h0;
    byteV  = curWord[{lane, 3'b000} +: 8];
    halfV  = lane[1] ? curWord[31:16] : curWord[15:0];
    case (opSize)
      2'b00: begin
        be     = 4'b0001 << lane;
        wWord  = {4{opWdata[7:0]}};
        ldData = {{24{~opUns & byteV[7]}}, byteV};
      end
      2'b01: begin
        be     = lane[1] ? 4'b1100 : 4'b0011;
        wWord  = {2{opWdata[15:0]}};
        ldData = {{16{~opUns & halfV[15]}}, halfV};
      end
      2'b10: begin
        be     = 4'b1111;
        ldData = curWord;
      end
      default: begin
        be     = 4'b0000;
        ldData = 32'h0;
      end
    endcase
    if (err) begin
      be     = 4'b0000;
      ldData = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      rdataQ <= 32'h0;
      errQ   <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (commit) begin
        errQ   <= err;
        rdataQ <= opWe ? 32'h0 : ldData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && bus.req_valid) begin
      weQ    <= bus.req_we;
      unsQ   <= bus.req_unsigned;
      sizeQ  <= bus.req_size;
      addrQ  <= bus.req_addr;
      wdataQ <= bus.req_wdata;
    end
  end

  // Storage ignores rst; only a commit edge outside reset can write it.
  always_ff @(posedge clk) begin
    if (!rst && commit && opWe) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wWord[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.rsp_valid = (state == RESP) && !rst;
  assign bus.rsp_rdata = rst ? 32'h0 : rdataQ;
  assign bus.rsp_err   = rst ? 1'b0  : errQ;
  assign dbgState      = state;
endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: two instances (LATENCY 1 and 3) share one driver,
// a byte-array reference model feeds a scoreboard drained by a monitor.
module tb_mem_port_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        reqValid, reqWe, reqUns, rspReady;
  logic [1:0]  reqSize;
  logic [9:0]  reqAddr;
  logic [31:0] reqWdata;
  logic [1:0]  dbgA, dbgB;
  logic        reqReady, rspValid, rspErr;
  logic [31:0] rspRdata;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  logic [32:0] exp_q[$];
  int          expCyc_q[$];
  int          hold_q[$];
  logic [31:0] mdl [2][256];

  logic        pending = 1'b0;
  logic        inResp = 1'b0;
  int          holdLeft = 0;
  logic [32:0] held;

  mem_port_if #(.ADDR_W(10)) ifA();
  mem_port_if #(.ADDR_W(10)) ifB();

  assign ifA.req_valid    = reqValid & ~sel;
  assign ifB.req_valid    = reqValid & sel;
  assign ifA.rsp_ready    = rspReady & ~sel;
  assign ifB.rsp_ready    = rspReady & sel;
  assign ifA.req_we       = reqWe;
  assign ifB.req_we       = reqWe;
  assign ifA.req_size     = reqSize;
  assign ifB.req_size     = reqSize;
  assign ifA.req_unsigned = reqUns;
  assign ifB.req_unsigned = reqUns;
  assign ifA.req_addr     = reqAddr;
  assign ifB.req_addr     = reqAddr;
  assign ifA.req_wdata    = reqWdata;
  assign ifB.req_wdata    = reqWdata;

  mem_port_ctrl #(.ADDR_W(10), .LATENCY(1), .INIT_ZERO(1)) dutA (
    .clk(clk), .rst(rst), .bus(ifA), .dbgState(dbgA)
  );
  mem_port_ctrl #(.ADDR_W(10), .LATENCY(3), .INIT_ZERO(1)) dutB (
    .clk(clk), .rst(rst), .bus(ifB), .dbgState(dbgB)
  );

  always_comb begin
    reqReady = sel ? ifB.req_ready : ifA.req_ready;
    rspValid = sel ? ifB.rsp_valid : ifA.rsp_valid;
    rspErr   = sel ? ifB.rsp_err   : ifA.rsp_err;
    rspRdata = sel ? ifB.rsp_rdata : ifA.rsp_rdata;
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [32:0] got, input logic [32:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int latOf(input int d);
    return (d != 0) ? 3 : 1;
  endfunction

  // Reference: memory as bytes, access of 1/2/4 bytes, result {err, data}.
  function automatic logic [32:0] modelAccess(input int d, input logic we, input logic [1:0] size,
                                              input logic uns, input logic [9:0] addr,
                                              input logic [31:0] wdata);
    int nb, off, w;
    logic [31:0] val;
    w = int'(addr) / 4;
    if (size == 2'b11) return {1'b1, 32'h0};
    nb  = 1 << int'(size);
    off = int'(addr) % 4;
`ifdef MEMPORT_MISALIGN_CHK_EN
    if (off % nb != 0) return {1'b1, 32'h0};
`else
    off = off - (off % nb);
`endif
    if (we) begin
      for (int i = 0; i < nb; i++) mdl[d][w][8*(off+i) +: 8] = wdata[8*i +: 8];
      return 33'h0;
    end
    val = 32'h0;
    for (int i = 0; i < nb; i++) val[8*i +: 8] = mdl[d][w][8*(off+i) +: 8];
    if (!uns && nb < 4 && val[8*nb-1]) begin
      for (int i = nb; i < 4; i++) val[8*i +: 8] = 8'hFF;
    end
    return {1'b0, val};
  endfunction

  task automatic waitIdle();
    int n = 0;
    while ((exp_q.size() != 0 || pending || inResp) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0 || pending || inResp) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete(); expCyc_q.delete(); hold_q.delete();
      pending = 1'b0; inResp = 1'b0; rspReady = 1'b0;
    end
  endtask

  task automatic doReq(input int d, input logic we, input logic [1:0] size, input logic uns,
                       input logic [9:0] addr, input logic [31:0] wdata, input int hold,
                       input logic useC, input logic [32:0] cExp);
    int n = 0;
    logic [32:0] e;
    if (sel != d[0]) begin
      waitIdle();
      sel = d[0];
    end
    @(negedge clk);
    while (!reqReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {32'h0, reqReady}, 33'd1);
    reqWe = we; reqSize = size; reqUns = uns; reqAddr = addr; reqWdata = wdata;
    reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    reqWdata = $urandom();
    reqAddr  = 10'($urandom());
    e = modelAccess(d, we, size, uns, addr, wdata);
    exp_q.push_back(useC ? cExp : e);
    expCyc_q.push_back(cyc + latOf(d));
    hold_q.push_back(hold);
  endtask

  // Monitor: pops one expectation per response handshake.
  initial begin
    rspReady = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (pending) begin
        pending  = 1'b0;
        inResp   = 1'b0;
        rspReady = 1'b0;
        void'(exp_q.pop_front());
        void'(expCyc_q.pop_front());
        void'(hold_q.pop_front());
        chk("rsp_valid_after_hs", {32'h0, rspValid}, 33'd0);
        chk("req_ready_after_hs", {32'h0, reqReady}, 33'd1);
      end else if (rspValid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", {32'h0, rspValid}, 33'd0);
        end else begin
          if (!inResp) begin
            inResp   = 1'b1;
            held     = {rspErr, rspRdata};
            holdLeft = hold_q[0];
            chk("rsp_latency", 33'(cyc), 33'(expCyc_q[0]));
            chk("rsp_err_data", {rspErr, rspRdata}, exp_q[0]);
          end else begin
            chk("rsp_stable", {rspErr, rspRdata}, held);
          end
          chk("req_ready_in_resp", {32'h0, reqReady}, 33'd0);
          if (holdLeft == 0) begin
            rspReady = 1'b1;
            pending  = 1'b1;
          end else begin
            holdLeft--;
          end
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 256; w++) mdl[d][w] = 32'h0;
    rst = 1'b1; sel = 1'b0; reqValid = 1'b0; reqWe = 1'b0; reqUns = 1'b0;
    reqSize = 2'b10; reqAddr = 10'h0; reqWdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready_a", {32'h0, ifA.req_ready}, 33'd0);
    chk("rst_req_ready_b", {32'h0, ifB.req_ready}, 33'd0);
    chk("rst_rsp_a", {ifA.rsp_valid, ifA.rsp_err, ifA.rsp_rdata}, 34'h0);
    chk("rst_rsp_b", {ifB.rsp_valid, ifB.rsp_err, ifB.rsp_rdata}, 34'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready_a", {32'h0, ifA.req_ready}, 33'd1);
    chk("post_rst_req_ready_b", {32'h0, ifB.req_ready}, 33'd1);

    // word store/load, then byte lanes with sign/zero extension
    doReq(0, 1'b1, 2'b10, 1'b0, 10'h004, 32'hDEADBEEF, 0, 1'b1, 33'h0);
    doReq(0, 1'b0, 2'b10, 1'b0, 10'h004, 32'h0, 0, 1'b1, {1'b0, 32'hDEADBEEF});
    doReq(0, 1'b1, 2'b00, 1'b0, 10'h005, 32'h00000080, 1, 1'b1, 33'h0);
    doReq(0, 1'b0, 2'b00, 1'b0, 10'h005, 32'h0, 0, 1'b1, {1'b0, 32'hFFFFFF80});
    doReq(0, 1'b0, 2'b00, 1'b1, 10'h005, 32'h0, 2, 1'b1, {1'b0, 32'h00000080});
    doReq(0, 1'b0, 2'b10, 1'b0, 10'h004, 32'h0, 0, 1'b1, {1'b0, 32'hDEAD80EF});

    // misaligned half store
    doReq(0, 1'b1, 2'b10, 1'b0, 10'h000, 32'hA5A5A5A5, 0, 1'b1, 33'h0);
`ifdef MEMPORT_MISALIGN_CHK_EN
    doReq(0, 1'b1, 2'b01, 1'b0, 10'h003, 32'h00001234, 0, 1'b1, {1'b1, 32'h0});
    doReq(0, 1'b0, 2'b10, 1'b0, 10'h000, 32'h0, 0, 1'b1, {1'b0, 32'hA5A5A5A5});
`else
    doReq(0, 1'b1, 2'b01, 1'b0, 10'h003, 32'h00001234, 0, 1'b1, 33'h0);
    doReq(0, 1'b0, 2'b10, 1'b0, 10'h000, 32'h0, 0, 1'b1, {1'b0, 32'h1234A5A5});
`endif

    // illegal size: error, no write
    doReq(0, 1'b1, 2'b10, 1'b0, 10'h020, 32'h0BADCAFE, 0, 1'b1, 33'h0);
    doReq(0, 1'b1, 2'b11, 1'b0, 10'h020, 32'hFFFFFFFF, 0, 1'b1, {1'b1, 32'h0});
    doReq(0, 1'b0, 2'b11, 1'b0, 10'h020, 32'h0, 1, 1'b1, {1'b1, 32'h0});
    doReq(0, 1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 0, 1'b1, {1'b0, 32'h0BADCAFE});

    // latency 3 with consumer back-pressure
    doReq(1, 1'b1, 2'b10, 1'b0, 10'h010, 32'h5A5A1234, 0, 1'b1, 33'h0);
    doReq(1, 1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 3, 1'b1, {1'b0, 32'h5A5A1234});

    // reset during WAIT abandons the store
    doReq(1, 1'b1, 2'b10, 1'b0, 10'h008, 32'hCAFEF00D, 0, 1'b1, 33'h0);
    doReq(1, 1'b0, 2'b10, 1'b0, 10'h008, 32'h0, 0, 1'b1, {1'b0, 32'hCAFEF00D});
    waitIdle();
    @(negedge clk);
    reqWe = 1'b1; reqSize = 2'b10; reqUns = 1'b0; reqAddr = 10'h008; reqWdata = 32'h11111111;
    reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_outputs", {ifB.req_ready, ifB.rsp_valid, ifB.rsp_err, ifB.rsp_rdata}, 35'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_release_ready", {32'h0, ifB.req_ready}, 33'd1);
    doReq(1, 1'b0, 2'b10, 1'b0, 10'h008, 32'h0, 0, 1'b1, {1'b0, 32'hCAFEF00D});

    // randomized traffic over a small address window on both instances
    for (int k = 0; k < 60; k++) begin
      doReq($urandom_range(0, 1), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 10'($urandom_range(0, 63)), $urandom(),
            $urandom_range(0, 2), 1'b0, 33'h0);
    end
    waitIdle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
